fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Requester side of the instruction-memory interface.
- Owns the PC and drives the instruction memory's address, kill and stall inputs each cycle.
- Selects the next PC from four sources: sequential, decode-stage jump/call/return, execute-stage branch redirect, and a small return-address stack (RAS).
- Sits in IF. Inputs come from the hazard unit (ID) and branch resolution (EX); outputs go to instruction memory and the IF/ID register.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset and on RAS underflow
RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall_in  input  1  hazard unit: hold PC and IR
branch_valid  input  1  EX: taken branch, redirect now
branch_target  input  16  EX branch target
jump_valid  input  1  ID: J or CALL, redirect to jump_target
jump_target  input  16  ID jump/call target
call  input  1  qualifies jump_valid; push return address
ret_valid  input  1  ID: RET, redirect to RAS top
imem_address  output  16  word address to instruction memory (= pc register)
imem_kill  output  1  to memory kill; memory loads NOP this edge
imem_stall  output  1  to memory stall; memory holds instruction
fetched_pc  output  16  PC of instruction now in memory output register
fetch_valid  output  1  memory output is a real (non-killed) instruction
ras_overflow  output  1  sticky: push while full
ras_underflow  output  1  sticky: pop while empty

Behaviour:
- Addressing: word-addressed. pc+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- Memory timing: memory registers the instruction at the same posedge on which pc updates, reading the pc value driven before that edge. Instruction latency is therefore one cycle from address.
- Reset (sync, while reset=1):
  - pc=RESET_PC; fetched_pc=RESET_PC; fetch_valid=0.
  - RAS pointer=0, count=0; ras_overflow=0; ras_underflow=0.
  - imem_kill=1 combinationally during reset; imem_stall=0.
  - Reset mid-operation discards all pending redirects and RAS contents.
- Next-PC priority, evaluated each cycle (highest first):
  1. reset
  2. branch_valid → branch_target. Honoured even when stall_in=1.
  3. ret_valid && !stall_in → RAS top, with pop. If RAS empty: RESET_PC and set ras_underflow.
  4. jump_valid && !stall_in → jump_target. If call=1, also push fetched_pc+1.
  5. stall_in → hold pc.
  6. otherwise → pc+1.
- ID inputs (jump/ret/call) are ignored while stall_in=1. Decode re-presents them after the stall, so no double push/pop occurs.
- redirect = any of priorities 2–4 taken.
- imem_kill = reset | redirect, combinational. This NOPs the wrong-path instruction being latched at that edge.
- imem_stall = stall_in & !redirect.
- Flushing IF/ID for an EX branch is the pipeline's job, not this block's.
- IR tracking at each edge:
  - if imem_stall: fetched_pc and fetch_valid hold.
  - else: fetched_pc <= pc; fetch_valid <= !imem_kill.
- RAS behaviour:
  - Circular buffer with a top pointer and occupancy count (0..RAS_DEPTH).
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH; ras_overflow set.
  - Pop decrements count, saturating at 0.
  - call and ret asserted together are illegal: ret wins, no push.
  - Sticky flags clear only on reset.
- Simultaneous events:
  - branch_valid with jump/ret: branch wins; ID request dropped; RAS unchanged.
  - branch_valid with stall_in: redirect, imem_stall=0, kill=1.
- No combinational path from imem inputs back to pc other than through registers.

Test Plan:
- Reset then 4 free-running cycles → imem_address 0,1,2,3. fetch_valid=0 on first edge after reset, 1 after. fetched_pc lags address by one cycle.
- stall_in=1 for 2 cycles at pc=5 → imem_address holds 5, imem_stall=1, fetched_pc holds 4. Release → address 6.
- jump_valid with target 16'h0040 at pc=8 → imem_kill=1 that cycle, next address 0x40, fetch_valid=0 for the killed slot. Same request with stall_in=1 → ignored.
- CALL at fetched_pc=0x10 to 0x80, then RET → address returns to 0x11. Five CALLs with RAS_DEPTH=4 → ras_overflow=1. Five RETs → fifth goes to RESET_PC, ras_underflow=1.
- branch_valid to 0x20 in the same cycle as jump_valid to 0x90 and stall_in=1 → next address 0x20, kill=1, imem_stall=0, RAS unchanged.
- pc=16'hFFFF sequential → 16'h0000. Reset asserted mid-CALL → RAS count 0, flags 0, address RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch requester. Owns the PC and each cycle drives the
// instruction memory's address, kill and stall inputs. The next PC is chosen
// from these sources, highest priority first:
//   - an EX-stage taken branch
//   - an ID-stage RET, which pops the return-address stack (RAS)
//   - an ID-stage jump or call; a call pushes fetched_pc+1
//   - a hazard stall
//   - the sequential pc+1
// The block also tracks which PC currently sits in the memory's output
// register, and whether that instruction is real or was killed.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall_in       hazard unit: hold PC and IR
//   branch_valid   EX: taken branch, redirect now (honoured even when stalled)
//   branch_target  EX branch target
//   jump_valid     ID: J or CALL, redirect to jump_target
//   jump_target    ID jump/call target
//   call           qualifies jump_valid; push return address
//   ret_valid      ID: RET, redirect to RAS top
//   imem_address   word address to instruction memory (= pc register)
//   imem_kill      memory loads a NOP at this edge
//   imem_stall     memory holds its instruction at this edge
//   fetched_pc     PC of the instruction now in the memory output register
//   fetch_valid    memory output is a real (non-killed) instruction
//   ras_overflow   sticky: push while the RAS is full
//   ras_underflow  sticky: pop while the RAS is empty
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  input  logic        jump_valid,
  input  logic [15:0] jump_target,
  input  logic        call,
  input  logic        ret_valid,
  output logic [15:0] imem_address,
  output logic        imem_kill,
  output logic        imem_stall,
  output logic [15:0] fetched_pc,
  output logic        fetch_valid,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);      // RAS pointer width
  localparam int CW = $clog2(RAS_DEPTH + 1);  // RAS occupancy width (0..DEPTH)

  logic [15:0]   pc_reg, pc_next;
  logic [15:0]   fetched_pc_reg;
  logic          fetch_valid_reg;
  logic [PW-1:0] ras_ptr_reg, ras_ptr_next;
  logic [CW-1:0] ras_count_reg, ras_count_next;
  logic          ras_overflow_reg, ras_underflow_reg;

  logic          take_branch, take_ret, take_jump, do_push, redirect;
  logic          ras_empty, ras_full;
  logic [PW-1:0] push_ptr;
  logic [15:0]   push_value;
  logic [15:0]   ras_top;
  logic [15:0]   ras_word [RAS_DEPTH];

  // ID-stage requests are only honoured when neither stalled nor overridden
  // by an EX branch. RET beats CALL when both are (illegally) presented.
  assign take_branch = branch_valid;
  assign take_ret    = !branch_valid && ret_valid && !stall_in;
  assign take_jump   = !branch_valid && !ret_valid && jump_valid && !stall_in;
  assign do_push     = take_jump && call;
  assign redirect    = take_branch || take_ret || take_jump;

  assign ras_empty  = (ras_count_reg == '0);
  assign ras_full   = (ras_count_reg == CW'(RAS_DEPTH));
  // The pointer wraps naturally because RAS_DEPTH is a power of two; a push
  // into a full stack therefore overwrites the oldest entry.
  assign push_ptr   = ras_ptr_reg + PW'(1);
  assign push_value = fetched_pc_reg + 16'd1;
  assign ras_top    = ras_word[ras_ptr_reg];

  // One register per RAS entry; contents need no reset because occupancy
  // count decides what is valid.
  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      logic [15:0] entry_reg;
      always_ff @(posedge clk) begin
        if (!reset && do_push && (push_ptr == PW'(gi))) begin
          entry_reg <= push_value;
        end
      end
      assign ras_word[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    pc_next        = pc_reg + 16'd1;
    ras_ptr_next   = ras_ptr_reg;
    ras_count_next = ras_count_reg;
    if (take_branch) begin
      pc_next = branch_target;
    end else if (take_ret) begin
      if (ras_empty) begin
        pc_next = RESET_PC;
      end else begin
        pc_next        = ras_top;
        ras_ptr_next   = ras_ptr_reg - PW'(1);
        ras_count_next = ras_count_reg - CW'(1);
      end
    end else if (take_jump) begin
      pc_next = jump_target;
      if (call) begin
        ras_ptr_next = push_ptr;
        if (!ras_full) begin
          ras_count_next = ras_count_reg + CW'(1);
        end
      end
    end else if (stall_in) begin
      pc_next = pc_reg;
    end
  end

  // Kill NOPs the wrong-path instruction the memory latches at this edge.
  assign imem_kill  = reset || redirect;
  assign imem_stall = stall_in && !redirect && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg            <= RESET_PC;
      fetched_pc_reg    <= RESET_PC;
      fetch_valid_reg   <= 1'b0;
      ras_ptr_reg       <= '0;
      ras_count_reg     <= '0;
      ras_overflow_reg  <= 1'b0;
      ras_underflow_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      ras_ptr_reg   <= ras_ptr_next;
      ras_count_reg <= ras_count_next;
      if (do_push && ras_full) begin
        ras_overflow_reg <= 1'b1;
      end
      if (take_ret && ras_empty) begin
        ras_underflow_reg <= 1'b1;
      end
      // Mirror the memory's output register: it captures the current pc
      // unless the memory is being told to hold.
      if (!imem_stall) begin
        fetched_pc_reg  <= pc_reg;
        fetch_valid_reg <= !imem_kill;
      end
    end
  end

  assign imem_address  = pc_reg;
  assign fetched_pc    = fetched_pc_reg;
  assign fetch_valid   = fetch_valid_reg;
  assign ras_overflow  = ras_overflow_reg;
  assign ras_underflow = ras_underflow_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic        call;
  logic        ret_valid;
  logic [15:0] imem_address;
  logic        imem_kill;
  logic        imem_stall;
  logic [15:0] fetched_pc;
  logic        fetch_valid;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  fetch_unit #(
    .RESET_PC  (16'h0000),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_in      (stall_in),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .call          (call),
    .ret_valid     (ret_valid),
    .imem_address  (imem_address),
    .imem_kill     (imem_kill),
    .imem_stall    (imem_stall),
    .fetched_pc    (fetched_pc),
    .fetch_valid   (fetch_valid),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_in      = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 16'h0000;
    jump_valid    = 1'b0;
    jump_target   = 16'h0000;
    call          = 1'b0;
    ret_valid     = 1'b0;
  endtask

  // Advance one clock; one line per transaction.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d addr=%h fpc=%h fv=%b ovf=%b unf=%b", cyc, imem_address,
             fetched_pc, fetch_valid, ras_overflow, ras_underflow);
  endtask

  task automatic do_call(input logic [15:0] target);
    jump_valid  = 1'b1;
    call        = 1'b1;
    jump_target = target;
    tick();
    idle();
  endtask

  task automatic do_ret();
    ret_valid = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset    = 1'b1;
    stall_in = 1'b1;             // must not leak to imem_stall during reset
    tick();
    tick();
    #1;
    check("rst_addr", imem_address, 16'h0000);
    check("rst_kill", {15'b0, imem_kill}, 16'd1);
    check("rst_stall", {15'b0, imem_stall}, 16'd0);
    check("rst_fpc", fetched_pc, 16'h0000);
    check("rst_fv", {15'b0, fetch_valid}, 16'd0);
    check("rst_flags", {14'b0, ras_overflow, ras_underflow}, 16'd0);

    // Free-running fetch
    reset = 1'b0;
    idle();
    #1;
    check("run_kill0", {15'b0, imem_kill}, 16'd0);
    check("run_fv0", {15'b0, fetch_valid}, 16'd0);
    tick();
    check("run_addr1", imem_address, 16'h0001);
    check("run_fpc1", fetched_pc, 16'h0000);
    check("run_fv1", {15'b0, fetch_valid}, 16'd1);
    tick();
    check("run_addr2", imem_address, 16'h0002);
    tick();
    check("run_addr3", imem_address, 16'h0003);
    check("run_fpc3", fetched_pc, 16'h0002);
    tick();
    tick();
    check("pre_stall_addr", imem_address, 16'h0005);

    // Stall for two cycles at pc=5
    stall_in = 1'b1;
    #1;
    check("stall_out", {15'b0, imem_stall}, 16'd1);
    check("stall_kill", {15'b0, imem_kill}, 16'd0);
    tick();
    tick();
    check("stall_addr", imem_address, 16'h0005);
    check("stall_fpc", fetched_pc, 16'h0004);
    stall_in = 1'b0;
    tick();
    check("unstall_addr", imem_address, 16'h0006);
    check("unstall_fpc", fetched_pc, 16'h0005);
    tick();
    tick();
    check("pre_jump_addr", imem_address, 16'h0008);

    // Jump at pc=8
    jump_valid  = 1'b1;
    jump_target = 16'h0040;
    #1;
    check("jump_kill", {15'b0, imem_kill}, 16'd1);
    tick();
    idle();
    check("jump_addr", imem_address, 16'h0040);
    check("jump_fpc", fetched_pc, 16'h0008);
    check("jump_fv", {15'b0, fetch_valid}, 16'd0);
    tick();
    check("jump_next", imem_address, 16'h0041);
    check("jump_fv_next", {15'b0, fetch_valid}, 16'd1);

    // Same jump while stalled is ignored
    jump_valid  = 1'b1;
    jump_target = 16'h0040;
    stall_in    = 1'b1;
    #1;
    check("sjump_kill", {15'b0, imem_kill}, 16'd0);
    check("sjump_stall", {15'b0, imem_stall}, 16'd1);
    tick();
    idle();
    check("sjump_addr", imem_address, 16'h0041);
    tick();
    check("sjump_after", imem_address, 16'h0042);

    // Get fetched_pc to 0x10 via a branch, then CALL / RET
    branch_valid  = 1'b1;
    branch_target = 16'h0010;
    tick();
    idle();
    check("br10_addr", imem_address, 16'h0010);
    tick();
    check("call_pre_fpc", fetched_pc, 16'h0010);
    do_call(16'h0080);
    check("call_addr", imem_address, 16'h0080);
    tick();
    check("call_next", imem_address, 16'h0081);
    ret_valid = 1'b1;
    #1;
    check("ret_kill", {15'b0, imem_kill}, 16'd1);
    tick();
    idle();
    check("ret_addr", imem_address, 16'h0011);
    tick();
    check("ret_next", imem_address, 16'h0012);

    // Five calls into a 4-deep RAS; pushes 0x12,0x101,0x201,0x301,0x401
    for (int k = 1; k <= 5; k++) begin
      do_call(16'(k * 16'h0100));
      check("ncall_addr", imem_address, 16'(k * 16'h0100));
      if (k == 4) check("ovf_at4", {15'b0, ras_overflow}, 16'd0);
      tick();
    end
    check("ovf_at5", {15'b0, ras_overflow}, 16'd1);

    // Five returns: four valid entries, then underflow to RESET_PC
    do_ret();
    check("ret1", imem_address, 16'h0401);
    tick();
    do_ret();
    check("ret2", imem_address, 16'h0301);
    tick();
    do_ret();
    check("ret3", imem_address, 16'h0201);
    tick();
    do_ret();
    check("ret4", imem_address, 16'h0101);
    check("unf_before", {15'b0, ras_underflow}, 16'd0);
    tick();
    do_ret();
    check("ret5", imem_address, 16'h0000);
    check("unf_after", {15'b0, ras_underflow}, 16'd1);
    tick();
    check("ret5_next", imem_address, 16'h0001);

    // Branch beats jump/call and stall; RAS must stay empty
    branch_valid  = 1'b1;
    branch_target = 16'h0020;
    jump_valid    = 1'b1;
    jump_target   = 16'h0090;
    call          = 1'b1;
    stall_in      = 1'b1;
    #1;
    check("bj_kill", {15'b0, imem_kill}, 16'd1);
    check("bj_stall", {15'b0, imem_stall}, 16'd0);
    tick();
    idle();
    check("bj_addr", imem_address, 16'h0020);
    tick();
    do_ret();
    check("bj_ras_empty", imem_address, 16'h0000);
    tick();

    // Wrap at 0xFFFF
    branch_valid  = 1'b1;
    branch_target = 16'hFFFF;
    tick();
    idle();
    check("wrap_ffff", imem_address, 16'hFFFF);
    tick();
    check("wrap_0", imem_address, 16'h0000);
    check("wrap_fpc", fetched_pc, 16'hFFFF);
    tick();

    // Push an entry, then reset during another call
    do_call(16'h0300);
    check("mid_call", imem_address, 16'h0300);
    reset       = 1'b1;
    jump_valid  = 1'b1;
    call        = 1'b1;
    jump_target = 16'h0400;
    tick();
    check("mrst_addr", imem_address, 16'h0000);
    check("mrst_flags", {14'b0, ras_overflow, ras_underflow}, 16'd0);
    check("mrst_fv", {15'b0, fetch_valid}, 16'd0);
    reset = 1'b0;
    idle();
    tick();
    check("mrst_run", imem_address, 16'h0001);
    do_ret();
    check("mrst_ras_empty", imem_address, 16'h0000);
    check("mrst_unf", {15'b0, ras_underflow}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
